// File: rtl/note_player.sv
// Plays back the notes held by note_recorder, one note per beat, with a two-cycle fetch gap between notes.
// Define NOTE_PLAYER_LOOP_EN to repeat playback until stop or reset instead of finishing after one pass.
module note_player #(
  parameter int ADDR_W      = 7,
  parameter int NOTE_W      = 3,
  parameter int BEAT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        rec_count,
  input  logic [NOTE_W-1:0] note_rd,
  output logic [ADDR_W-1:0] query,
  output logic [NOTE_W-1:0] tone,
  output logic              tone_valid,
  output logic              busy,
  output logic              done
);

  localparam int          LEN_W   = ADDR_W + 1;
  localparam int unsigned MAX_LEN = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    FIN
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        beat_q;
  logic [ADDR_W-1:0] query_q;
  logic [NOTE_W-1:0] tone_q;
  logic              tone_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [LEN_W-1:0]  idx_d;

  // idx is one bit wider than query so a full 2**ADDR_W-note recording ends without wrapping.
  assign idx_d = idx_q + LEN_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      query_q      <= '0;
      tone_q       <= '0;
      tone_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop && (state_q != IDLE)) begin
        state_q      <= IDLE;
        idx_q        <= '0;
        query_q      <= '0;
        tone_q       <= '0;
        tone_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              busy_q  <= 1'b1;
              idx_q   <= '0;
              query_q <= '0;
              if (rec_count != 8'd0) begin
                if (32'(rec_count) > MAX_LEN) len_q <= LEN_W'(MAX_LEN);
                else                          len_q <= LEN_W'(rec_count);
                state_q <= FETCH;
              end else begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end
            end
          end
          FETCH: state_q <= LOAD;
          // The extra settle cycle lets a registered recorder read land before sampling.
          LOAD: begin
            tone_q       <= note_rd;
            tone_valid_q <= (note_rd != '0);
            beat_q       <= '0;
            state_q      <= PLAY;
          end
          PLAY: begin
            if (beat_q == 8'(BEAT_CYCLES - 1)) begin
              tone_q       <= '0;
              tone_valid_q <= 1'b0;
              if (idx_d < len_q) begin
                idx_q   <= idx_d;
                query_q <= idx_d[ADDR_W-1:0];
                state_q <= FETCH;
              end else begin
`ifdef NOTE_PLAYER_LOOP_EN
                idx_q   <= '0;
                query_q <= '0;
                state_q <= FETCH;
`else
                query_q <= '0;
                done_q  <= 1'b1;
                state_q <= FIN;
`endif
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
          FIN: begin
            busy_q  <= 1'b0;
            query_q <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign query      = query_q;
  assign tone       = tone_q;
  assign tone_valid = tone_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/note_player.md
# note_player

Playback stage directly downstream of `note_recorder`. On a start request it walks the recorder's stored notes from index 0 to `count-1` by driving the recorder's `query` address, and emits each note as a tone held for a fixed number of clock cycles. Note code 0 plays as a rest. The block sits between the recorder and the tone generator / output driver.

## Interface
Parameters:
- `ADDR_W`, 7: width of the query address; matches the recorder's `query`.
- `NOTE_W`, 3: width of a note code; matches the recorder's `note_out`.
- `BEAT_CYCLES`, 4: clock cycles each note is played; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Assertion immediately forces the reset state; release is synchronous to `clk`.
- `start`  in  1: one-cycle request to begin playback. Honoured only in IDLE.
- `stop`  in  1: abort playback. Highest priority after reset.
- `rec_count`  in  8: number of stored notes (the recorder's `count`).
- `note_rd`  in  NOTE_W: note at address `query` (the recorder's `note_out`).
- `query`  out  ADDR_W: read address driven to the recorder.
- `tone`  out  NOTE_W: note currently playing; 0 when not playing.
- `tone_valid`  out  1: high while a non-zero note is playing.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when playback completes normally.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, FIN.
- IDLE:
  - `start`=1 and `rec_count`≠0: latch `len = min(rec_count, 128)`, set `idx=0`, go to FETCH.
  - `start`=1 and `rec_count`=0: go to FIN.
- FETCH: `query=idx`. Go to LOAD.
- LOAD: `query=idx`. Register `note_rd` into `cur`, clear the beat counter, go to PLAY. The one-cycle settle makes the block correct for both combinational and one-cycle-registered recorder reads.
- PLAY:
  - `tone=cur` and `tone_valid=(cur≠0)`.
  - The beat counter counts 0..BEAT_CYCLES-1.
  - At terminal count: if `idx+1 < len`, increment `idx` and go to FETCH; otherwise go to FIN.
- FIN: `done`=1 for this single cycle, then go to IDLE.
- `stop`=1 in any non-IDLE state: next state is IDLE, `tone`/`tone_valid` cleared, no `done` pulse.
- `start` is ignored while `busy`=1. `len` is not re-sampled mid-playback; changes to `rec_count` during playback have no effect.
- `stop` and `start` asserted together in IDLE: `stop` wins and the block stays in IDLE.
- `idx` is ADDR_W+1 bits wide internally, so `len`=128 terminates without wrapping; `query` takes the low ADDR_W bits.

## Timing
- Reset values: `query`=0, `tone`=0, `tone_valid`=0, `busy`=0, `done`=0. State=IDLE, `idx`=0, `len`=0.
- All outputs are registered.
- `start` sampled at edge T: FETCH is active during cycle T+1, LOAD during T+2, PLAY during T+3..T+2+BEAT_CYCLES.
- Period per note = BEAT_CYCLES+2 cycles. `tone_valid` is low for the 2 FETCH/LOAD cycles between notes (articulation gap).
- Total playback from `start` to `done` = len·(BEAT_CYCLES+2)+1 cycles. `done` is high in cycle T+1+len·(BEAT_CYCLES+2). Empty case: `done` is high in cycle T+1.
- `busy` rises in cycle T+1 and falls the cycle after `done`.
- `stop` sampled at edge S: IDLE and all outputs at reset values from cycle S+1.
- Reset asserted mid-playback: outputs return to reset values immediately (asynchronously); no `done` pulse.

## Configuration
- `NOTE_PLAYER_LOOP_EN` defined:
  - At the end of the last PLAY, the block returns to FETCH with `idx=0` instead of entering FIN.
  - Playback repeats until `stop` or reset; `done` never pulses.
  - `len` stays latched across loops.
- `NOTE_PLAYER_LOOP_EN` undefined: single pass as described above; the loop logic is absent.

## Test plan
- Reset release, then `rec_count`=3 with recorder contents {1,2,3}, `start` at edge T, BEAT_CYCLES=4 -> `query` 0,1,2 in turn; `tone`=1 during T+3..T+6, `tone`=2 during T+9..T+12, `tone`=3 during T+15..T+18; `done` high in T+19 only; `busy` low from T+20.
- `rec_count`=0, `start` -> `done` high in T+1 only; `tone_valid` never rises; `query` stays 0.
- Contents {5,0,4}, `rec_count`=3 -> `tone_valid` low for the whole second beat (rest) while `busy`=1; `tone`=0 during that beat.
- `stop` asserted in the 2nd PLAY cycle of note 1 -> IDLE next cycle, `tone`=0, `busy`=0, no `done`. A new `start` replays from `query`=0.
- `start` re-pulsed mid-playback and `rec_count` changed 3→7 mid-playback -> no effect; exactly 3 notes are played.
- `reset` driven low mid-PLAY, asynchronous to `clk` -> all outputs 0 before the next edge. With `NOTE_PLAYER_LOOP_EN` and `rec_count`=2: `query` sequence 0,1,0,1,… with no `done` until `stop`.
